branch_resolve: RTL and testbench

//  Checking end of the fetch next-PC predictor. Keeps an in-order queue of fetch-pair predictions
//  {pc, pred_next_pc} and compares each against the true next fetch-pair address from execute.
//  On mismatch it flushes the queue and holds branch_predict_fail/redirect_pc until fetch accepts.

---
 rtl/branch_resolve.sv | 99 +++++++++
 tb/tb_branch_resolve.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: in-order queue of fetch-pair predictions checked against execute; raises a held redirect on mispredict.
// Define BRANCH_RESOLVE_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolve #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pred_valid,
  output logic        pred_ready,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_next_pc,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_next_pc,
  output logic        branch_predict_fail,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        order_err,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispredict,
`endif
  input  logic        cp0_flush,
  input  logic        eret
);
  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t             r_state, w_next;
  logic [31:0]        r_pc  [DEPTH];
  logic [31:0]        r_npc [DEPTH];
  logic [PTR_W-1:0]   r_wr, r_rd;
  logic [PTR_W:0]     r_cnt;
  logic               r_live;
  logic [31:0]        r_redirect_pc;
  logic               r_order_err;
  logic               w_flush, w_full, w_empty, w_push, w_pop, w_mis;
  assign w_flush = cp0_flush | eret;
  assign w_full  = r_cnt == (PTR_W+1)'(DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_push  = pred_valid & pred_ready & ~w_flush;
  assign w_pop   = res_valid & res_ready & ~w_flush;
  assign w_mis   = w_pop && (res_next_pc != r_npc[r_rd]);
  assign redirect_pc = r_redirect_pc;
  assign order_err   = r_order_err;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = w_flush ? IDLE :
             (r_state == IDLE) ? (w_mis ? REDIRECT : IDLE) :
             (redirect_ready ? IDLE : REDIRECT);
  // readies depend only on registered state/count, never on the valids
  always_comb begin
    pred_ready          = r_live && r_state == IDLE && !w_full;
    res_ready           = r_state == IDLE && !w_empty;
    branch_predict_fail = r_state == REDIRECT;
  end
  always_ff @(posedge clk)
    if (w_push) begin
      r_pc[r_wr]  <= pred_pc;
      r_npc[r_wr] <= pred_next_pc;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_live        <= 1'b0;
      r_redirect_pc <= '0;
      r_order_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_flush || w_mis) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop) r_rd <= r_rd + 1'b1;
        r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
      if (w_mis) r_redirect_pc <= res_next_pc;
      if (w_pop && res_pc != r_pc[r_rd]) r_order_err <= 1'b1;
    end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] r_stat_res, r_stat_mis;
  assign stat_resolved   = r_stat_res;
  assign stat_mispredict = r_stat_mis;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_stat_res <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_pop && r_stat_res != '1) r_stat_res <= r_stat_res + 1'b1;
      if (w_mis && r_stat_mis != '1) r_stat_mis <= r_stat_mis + 1'b1;
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vectors; resolve outcomes go through a scoreboard checked by a separate monitor.
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        resetn, pred_valid, res_valid, redirect_ready, cp0_flush, eret;
  logic [31:0] pred_pc, pred_next_pc, res_pc, res_next_pc;
  logic        pred_ready, res_ready, branch_predict_fail, order_err;
  logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif
  typedef struct {logic fail; logic [31:0] rpc;} exp_t;
  exp_t        sb[$];
  logic [31:0] last_rpc;
  int          tests = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  branch_resolve dut (
    .clk(clk), .resetn(resetn),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc), .pred_next_pc(pred_next_pc),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_next_pc(res_next_pc),
    .branch_predict_fail(branch_predict_fail), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .order_err(order_err),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict),
`endif
    .cp0_flush(cp0_flush), .eret(eret)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    tests++;
    errs++;
    $display("FAIL %s: handshake timeout", name);
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] npc);
    int n = 0;
    pred_valid = 1'b1;
    pred_pc = pc;
    pred_next_pc = npc;
    while (!pred_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout("push");
    else begin
      @(posedge clk); #1;
    end
    pred_valid = 1'b0;
  endtask
  task automatic resolve(input logic [31:0] pc, input logic [31:0] npc, input logic fail);
    int n = 0;
    exp_t e;
    e.fail = fail;
    e.rpc = fail ? npc : last_rpc;
    last_rpc = e.rpc;
    res_valid = 1'b1;
    res_pc = pc;
    res_next_pc = npc;
    while (!res_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout("resolve");
    else begin
      sb.push_back(e);
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
  endtask
  // monitor: a handshake seen before an edge is checked on the following negedge
  initial begin
    logic pend = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) timeout("scoreboard_underflow");
        else begin
          e = sb.pop_front();
          chk("sb_fail", 32'(branch_predict_fail), 32'(e.fail));
          chk("sb_redirect_pc", redirect_pc, e.rpc);
        end
      end
      pend = resetn && res_valid && res_ready && !cp0_flush && !eret;
    end
  end
  initial begin
    resetn = 1'b0; pred_valid = 1'b0; res_valid = 1'b0; redirect_ready = 1'b0;
    cp0_flush = 1'b0; eret = 1'b0; pred_pc = '0; pred_next_pc = '0; res_pc = '0; res_next_pc = '0;
    last_rpc = '0;
    #2;
    chk("rst_pred_ready", 32'(pred_ready), 0);
    chk("rst_res_ready", 32'(res_ready), 0);
    chk("rst_fail", 32'(branch_predict_fail), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_order_err", 32'(order_err), 0);
    @(negedge clk); resetn = 1'b1;
    #1 chk("release_pred_ready_low", 32'(pred_ready), 0);
    @(posedge clk); #1;
    chk("first_edge_pred_ready", 32'(pred_ready), 1);
    push(32'hbfc00000, 32'hbfc00008);
    resolve(32'hbfc00000, 32'hbfc00008, 1'b0);
    chk("clean_empty", 32'(res_ready), 0);
    push(32'hbfc00020, 32'hbfc00028);
    push(32'hbfc00028, 32'hbfc00030);
    push(32'hbfc00030, 32'hbfc00038);
    push(32'hbfc00038, 32'hbfc00040);
    chk("full_pred_ready", 32'(pred_ready), 0);
    pred_valid = 1'b1; pred_pc = 32'hbfc00040; pred_next_pc = 32'hbfc00048;
    res_valid = 1'b1; res_pc = 32'hbfc00020; res_next_pc = 32'hbfc00028;
    sb.push_back('{1'b0, last_rpc});
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("full_pop_refused", 32'(pred_ready), 1);
    @(posedge clk); #1;
    pred_valid = 1'b0;
    chk("accepted_next_full", 32'(pred_ready), 0);
    resolve(32'hbfc00028, 32'hbfc00030, 1'b0);
    resolve(32'hbfc00030, 32'hbfc00038, 1'b0);
    resolve(32'hbfc00038, 32'hbfc00040, 1'b0);
    resolve(32'hbfc00040, 32'hbfc00048, 1'b0);
    chk("drained_empty", 32'(res_ready), 0);
    push(32'hbfc00010, 32'hbfc00018);
    resolve(32'hbfc00010, 32'hbfc00100, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("redirect_hold_fail", 32'(branch_predict_fail), 1);
      chk("redirect_hold_pc", redirect_pc, 32'hbfc00100);
      chk("redirect_pred_ready", 32'(pred_ready), 0);
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    chk("redirect_cleared", 32'(branch_predict_fail), 0);
    chk("redirect_pc_kept", redirect_pc, 32'hbfc00100);
    chk("redirect_empty", 32'(res_ready), 0);
    push(32'hbfc00050, 32'hbfc00058);
    push(32'hbfc00058, 32'hbfc00060);
    push(32'hbfc00060, 32'hbfc00068);
    resolve(32'hbfc00050, 32'hbfc00200, 1'b1);
    cp0_flush = 1'b1;
    @(posedge clk); #1;
    cp0_flush = 1'b0;
    chk("flush_fail", 32'(branch_predict_fail), 0);
    chk("flush_empty", 32'(res_ready), 0);
    chk("flush_pred_ready", 32'(pred_ready), 1);
    chk("flush_pc_kept", redirect_pc, 32'hbfc00200);
    push(32'hbfc00080, 32'hbfc00088);
    push(32'hbfc00088, 32'hbfc00090);
    push(32'hbfc00090, 32'hbfc00098);
    eret = 1'b1;
    @(posedge clk); #1;
    eret = 1'b0;
    chk("eret_empty", 32'(res_ready), 0);
    chk("eret_no_fail", 32'(branch_predict_fail), 0);
    push(32'hbfc00020, 32'hbfc00028);
    push(32'hbfc00030, 32'hbfc00038);
    resolve(32'hbfc00040, 32'hbfc00028, 1'b0);
    chk("order_err_set", 32'(order_err), 1);
    resolve(32'hbfc00030, 32'hbfc00038, 1'b0);
    chk("order_err_sticky", 32'(order_err), 1);
    push(32'hbfc00070, 32'hbfc00078);
    resolve(32'hbfc00070, 32'hbfc00300, 1'b1);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_resolved", stat_resolved, 11);
    chk("stat_mispredict", stat_mispredict, 3);
`endif
    @(posedge clk); #3;
    chk("pre_reset_fail", 32'(branch_predict_fail), 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_fail", 32'(branch_predict_fail), 0);
    chk("async_rst_pc", redirect_pc, 0);
    chk("async_rst_order_err", 32'(order_err), 0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("async_rst_stat_res", stat_resolved, 0);
    chk("async_rst_stat_mis", stat_mispredict, 0);
`endif
    #10 resetn = 1'b1;
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
